// File: rtl/bcd_timer_core.sv
// BCD stopwatch / countdown core: editable HH:MM:SS (or MM:SS) digits, up/down run,
// pause/resume and a blinking expiry alarm, with an ASCII rendering for the LCD path.
module bcd_timer_core #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned BLINK_TICKS   = 25_000_000,
    parameter int unsigned HOUR_EN       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        ack,
    input  logic        dir,
    input  logic [2:0]  sel,
    input  logic        inc,
    input  logic        dec,
    output logic [23:0] digits,
    output logic        running,
    output logic        expired,
    output logic        blink,
    output logic        sec_pulse,
    output logic [63:0] ascii_row
);

    localparam int unsigned   PW         = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned   BW         = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
    localparam logic [23:0]   MAX_DIGITS = (HOUR_EN != 0) ? 24'h235959 : 24'h005959;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [23:0]     digits_q, digits_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic            dir_q, dir_d;
    logic            blink_q, blink_d;
    logic            sec_pulse_q, sec_pulse_d;
    logic            running_q, running_d;
    logic            expired_q, expired_d;
    logic [63:0]     ascii_q;

    logic            at_last_c;
    logic [23:0]     step_c;
    logic            hit_c;
    logic            idle_done_c;

    function automatic logic [3:0] wrap_step(input logic [3:0] v, input logic [3:0] vmax,
                                             input logic up);
        if (up) return (v >= vmax) ? 4'd0 : v + 4'd1;
        return (v == 4'd0) ? vmax : v - 4'd1;
    endfunction

    function automatic logic [23:0] edit_digits(input logic [23:0] d, input logic [2:0] s,
                                                input logic up);
        logic [23:0] r;
        logic [3:0]  hu_max;
        r      = d;
        hu_max = (d[23:20] == 4'd2) ? 4'd3 : 4'd9;
        case (s)
            3'd0: r[3:0]   = wrap_step(d[3:0], 4'd9, up);
            3'd1: r[7:4]   = wrap_step(d[7:4], 4'd5, up);
            3'd2: r[11:8]  = wrap_step(d[11:8], 4'd9, up);
            3'd3: r[15:12] = wrap_step(d[15:12], 4'd5, up);
            3'd4: if (HOUR_EN != 0) r[19:16] = wrap_step(d[19:16], hu_max, up);
            3'd5: if (HOUR_EN != 0) begin
                r[23:20] = wrap_step(d[23:20], 4'd2, up);
                // 2x hours only go to 23, so pull the units digit into range
                if (r[23:20] == 4'd2 && r[19:16] > 4'd3) r[19:16] = 4'd3;
            end
            default: ;
        endcase
        return r;
    endfunction

    // Only applied to a nonzero value, so the borrow never runs past the top digit.
    function automatic logic [23:0] bcd_down(input logic [23:0] d);
        logic [23:0] r;
        r = d;
        if (r[3:0] != 4'd0) r[3:0] = r[3:0] - 4'd1;
        else begin
            r[3:0] = 4'd9;
            if (r[7:4] != 4'd0) r[7:4] = r[7:4] - 4'd1;
            else begin
                r[7:4] = 4'd5;
                if (r[11:8] != 4'd0) r[11:8] = r[11:8] - 4'd1;
                else begin
                    r[11:8] = 4'd9;
                    if (r[15:12] != 4'd0) r[15:12] = r[15:12] - 4'd1;
                    else begin
                        r[15:12] = 4'd5;
                        if (r[19:16] != 4'd0) r[19:16] = r[19:16] - 4'd1;
                        else begin
                            r[19:16] = 4'd9;
                            r[23:20] = r[23:20] - 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    // Only applied below the maximum, so the carry never overflows the hours.
    function automatic logic [23:0] bcd_up(input logic [23:0] d);
        logic [23:0] r;
        r = d;
        if (r[3:0] != 4'd9) r[3:0] = r[3:0] + 4'd1;
        else begin
            r[3:0] = 4'd0;
            if (r[7:4] != 4'd5) r[7:4] = r[7:4] + 4'd1;
            else begin
                r[7:4] = 4'd0;
                if (r[11:8] != 4'd9) r[11:8] = r[11:8] + 4'd1;
                else begin
                    r[11:8] = 4'd0;
                    if (r[15:12] != 4'd5) r[15:12] = r[15:12] + 4'd1;
                    else begin
                        r[15:12] = 4'd0;
                        if (r[19:16] == 4'd9 || (r[23:20] == 4'd2 && r[19:16] == 4'd3)) begin
                            r[19:16] = 4'd0;
                            r[23:20] = r[23:20] + 4'd1;
                        end else begin
                            r[19:16] = r[19:16] + 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] asc_digit(input logic [3:0] v);
        return 8'h30 + {4'h0, v};
    endfunction

    function automatic logic [63:0] to_ascii(input logic [23:0] d);
        logic [63:0] r;
        r = {asc_digit(d[23:20]), asc_digit(d[19:16]), 8'h3A,
             asc_digit(d[15:12]), asc_digit(d[11:8]),  8'h3A,
             asc_digit(d[7:4]),   asc_digit(d[3:0])};
        if (HOUR_EN == 0) r[63:40] = {3{8'h20}};
        return r;
    endfunction

    assign at_last_c   = (presc_q == PRESC_LAST);
    assign step_c      = dir_q ? bcd_up(digits_q) : bcd_down(digits_q);
    assign hit_c       = dir_q ? (step_c == MAX_DIGITS) : (step_c == 24'h0);
    // Starting from a value that is already the end point expires immediately.
    assign idle_done_c = dir ? (digits_q == MAX_DIGITS) : (digits_q == 24'h0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic, clear > ack > stop > start > tick
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_d = idle_done_c ? S_DONE : S_RUN;
                S_RUN: begin
                    if (stop)                    state_d = S_PAUSE;
                    else if (at_last_c && hit_c) state_d = S_DONE;
                end
                S_PAUSE: if (!stop && start) state_d = S_RUN;
                S_DONE:  if (ack) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        digits_d    = digits_q;
        presc_d     = presc_q;
        dir_d       = dir_q;
        blink_d     = blink_q;
        bcnt_d      = bcnt_q;
        sec_pulse_d = 1'b0;
        if (clear) begin
            digits_d = 24'h0;
            presc_d  = '0;
            blink_d  = 1'b0;
            bcnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        dir_d   = dir;
                        presc_d = '0;
                    end else if (inc ^ dec) begin
                        digits_d = edit_digits(digits_q, sel, inc);
                    end
                end
                S_RUN: begin
                    if (!stop) begin
                        if (at_last_c) begin
                            presc_d     = '0;
                            sec_pulse_d = 1'b1;
                            digits_d    = step_c;
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        blink_d = 1'b0;
                        bcnt_d  = '0;
                    end else if (bcnt_q == BLINK_LAST) begin
                        bcnt_d  = '0;
                        blink_d = ~blink_q;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
                default: ;
            endcase
            if (state_d == S_DONE && state_q != S_DONE) begin
                blink_d = 1'b1;
                bcnt_d  = '0;
            end
        end
        running_d = (state_d == S_RUN);
        expired_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q    <= 24'h0;
            presc_q     <= '0;
            bcnt_q      <= '0;
            dir_q       <= 1'b0;
            blink_q     <= 1'b0;
            sec_pulse_q <= 1'b0;
            running_q   <= 1'b0;
            expired_q   <= 1'b0;
            ascii_q     <= to_ascii(24'h0);
        end else begin
            digits_q    <= digits_d;
            presc_q     <= presc_d;
            bcnt_q      <= bcnt_d;
            dir_q       <= dir_d;
            blink_q     <= blink_d;
            sec_pulse_q <= sec_pulse_d;
            running_q   <= running_d;
            expired_q   <= expired_d;
            ascii_q     <= to_ascii(digits_q);
        end
    end

    assign digits    = digits_q;
    assign running   = running_q;
    assign expired   = expired_q;
    assign blink     = blink_q;
    assign sec_pulse = sec_pulse_q;
    assign ascii_row = ascii_q;

endmodule

// File: tb/tb_bcd_timer_core.sv
// Bench for bcd_timer_core: directed scenarios with literal expectations, then random
// pulses, all outputs compared every cycle against a seconds-based reference model.
module tb_bcd_timer_core;

    localparam int T    = 4;
    localparam int B    = 2;
    localparam int MAXS = 23 * 3600 + 59 * 60 + 59;
    localparam int MI = 0, MR = 1, MP = 2, MD = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, clear = 1'b0, ack = 1'b0, dir = 1'b0;
    logic        inc = 1'b0, dec = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic [23:0] digits;
    logic        running, expired, blink, sec_pulse;
    logic [63:0] ascii_row;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // reference model: digit array for edits, total seconds for counting
    int m_state = MI;
    int m_dig[6];
    int m_asc_dig[6];
    int m_presc = 0, m_dir = 0, m_done_cyc = 0;
    bit m_sp = 1'b0;

    always #5 clk = ~clk;

    bcd_timer_core #(.TICKS_PER_SEC(T), .BLINK_TICKS(B), .HOUR_EN(1)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .ack(ack),
        .dir(dir), .sel(sel), .inc(inc), .dec(dec), .digits(digits), .running(running),
        .expired(expired), .blink(blink), .sec_pulse(sec_pulse), .ascii_row(ascii_row)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    function automatic int cur_sec();
        return ((m_dig[5] * 10 + m_dig[4]) * 60 + m_dig[3] * 10 + m_dig[2]) * 60
               + m_dig[1] * 10 + m_dig[0];
    endfunction

    task automatic set_sec(input int s);
        int h, m, x;
        h = s / 3600; m = (s / 60) % 60; x = s % 60;
        m_dig[0] = x % 10; m_dig[1] = x / 10;
        m_dig[2] = m % 10; m_dig[3] = m / 10;
        m_dig[4] = h % 10; m_dig[5] = h / 10;
    endtask

    function automatic logic [23:0] pack6(input int d5, d4, d3, d2, d1, d0);
        return {4'(d5), 4'(d4), 4'(d3), 4'(d2), 4'(d1), 4'(d0)};
    endfunction

    function automatic logic [63:0] text_of(input int d5, d4, d3, d2, d1, d0);
        return {8'(48 + d5), 8'(48 + d4), 8'h3A, 8'(48 + d3), 8'(48 + d2), 8'h3A,
                8'(48 + d1), 8'(48 + d0)};
    endfunction

    task automatic model_edit(input int s, input bit up);
        int lim[6];
        lim[0] = 9; lim[1] = 5; lim[2] = 9; lim[3] = 5; lim[5] = 2;
        lim[4] = (m_dig[5] == 2) ? 3 : 9;
        if (s <= 5) begin
            if (up) m_dig[s] = (m_dig[s] == lim[s]) ? 0 : m_dig[s] + 1;
            else    m_dig[s] = (m_dig[s] == 0) ? lim[s] : m_dig[s] - 1;
            if (s == 5 && m_dig[5] == 2 && m_dig[4] > 3) m_dig[4] = 3;
        end
    endtask

    task automatic model_step();
        int s;
        for (int i = 0; i < 6; i++) m_asc_dig[i] = m_dig[i];
        m_sp = 1'b0;
        if (clear) begin
            for (int i = 0; i < 6; i++) m_dig[i] = 0;
            m_presc = 0;
            m_state = MI;
        end else begin
            case (m_state)
                MI: if (start) begin
                    m_dir = int'(dir); m_presc = 0; s = cur_sec();
                    if ((!dir && s == 0) || (dir && s == MAXS)) begin
                        m_state = MD; m_done_cyc = 0;
                    end else m_state = MR;
                end else if (inc != dec) model_edit(int'(sel), inc);
                MR: if (stop) m_state = MP;
                else if (m_presc == T - 1) begin
                    m_presc = 0; m_sp = 1'b1;
                    s = cur_sec() + ((m_dir != 0) ? 1 : -1);
                    set_sec(s);
                    if ((m_dir != 0 && s == MAXS) || (m_dir == 0 && s == 0)) begin
                        m_state = MD; m_done_cyc = 0;
                    end
                end else m_presc++;
                MP: if (!stop && start) m_state = MR;
                default: if (ack) m_state = MI; else m_done_cyc++;
            endcase
        end
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin m_dig[i] = 0; m_asc_dig[i] = 0; end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_state = MI; m_presc = 0; m_dir = 0; m_done_cyc = 0; m_sp = 1'b0;
                for (int i = 0; i < 6; i++) begin m_dig[i] = 0; m_asc_dig[i] = 0; end
            end else begin
                model_step();
            end
        end
    end

    // per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (cmp_en && !rst) begin
            chk("digits", 64'(digits),
                64'(pack6(m_dig[5], m_dig[4], m_dig[3], m_dig[2], m_dig[1], m_dig[0])));
            chk("running", 64'(running), 64'(m_state == MR));
            chk("expired", 64'(expired), 64'(m_state == MD));
            chk("blink", 64'(blink), 64'(m_state == MD && ((m_done_cyc / B) % 2) == 0));
            chk("sec_pulse", 64'(sec_pulse), 64'(m_sp));
            chk("ascii_row", ascii_row, text_of(m_asc_dig[5], m_asc_dig[4], m_asc_dig[3],
                                                m_asc_dig[2], m_asc_dig[1], m_asc_dig[0]));
        end
    end

    task automatic drive(input logic st, sp, cl, ak, ic, dc);
        @(negedge clk);
        start = st; stop = sp; clear = cl; ack = ak; inc = ic; dec = dc;
    endtask

    task automatic quiet(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic pulse(input logic st, sp, cl, ak, ic, dc);
        drive(st, sp, cl, ak, ic, dc);
        quiet(1);
    endtask

    task automatic set_time(input logic [23:0] v);
        pulse(0, 0, 1, 0, 0, 0);
        for (int i = 5; i >= 0; i--) begin
            sel = 3'(i);
            repeat (int'(v[4*i +: 4])) pulse(0, 0, 0, 0, 1, 0);
        end
    endtask

    task automatic wait_pulse(output int k);
        k = -1;
        for (int c = 1; c <= 12 && k < 0; c++) begin
            @(negedge clk);
            if (sec_pulse) k = c;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        logic [3:0] bexp;
        repeat (2) @(negedge clk);
        chk("rst_digits", 64'(digits), 64'(24'h0));
        chk("rst_ascii", ascii_row, 64'h30303A30303A3030);
        chk("rst_flags", 64'({running, expired, blink, sec_pulse}), 64'(4'b0));
        rst = 1'b0;
        cmp_en = 1'b1;

        // edits: seconds-tens wrap, hour-tens with units clamp
        pulse(0, 0, 1, 0, 0, 0);
        sel = 3'd1;
        for (int i = 1; i <= 6; i++) begin
            pulse(0, 0, 0, 0, 1, 0);
            chk("edit_st", 64'(digits), 64'(24'((i % 6) << 4)));
        end
        sel = 3'd4;
        repeat (7) pulse(0, 0, 0, 0, 1, 0);
        sel = 3'd5;
        pulse(0, 0, 0, 0, 1, 0); chk("edit_ht1", 64'(digits), 64'(24'h170000));
        pulse(0, 0, 0, 0, 1, 0); chk("edit_ht2", 64'(digits), 64'(24'h230000));
        pulse(0, 0, 0, 0, 1, 0); chk("edit_ht0", 64'(digits), 64'(24'h030000));
        sel = 3'd0;
        pulse(0, 0, 0, 0, 0, 1); chk("edit_dec_wrap", 64'(digits), 64'(24'h030009));
        pulse(0, 0, 0, 0, 1, 1); chk("edit_incdec", 64'(digits), 64'(24'h030009));

        // countdown 00:00:02 to expiry and blink
        set_time(24'h000002);
        dir = 1'b0;
        pulse(1, 0, 0, 0, 0, 0);
        chk("cd_running", 64'(running), 64'(1));
        wait_pulse(k); chk("cd_period1", 64'(k), 64'(4));
        chk("cd_digits1", 64'(digits), 64'(24'h000001));
        wait_pulse(k); chk("cd_period2", 64'(k), 64'(4));
        chk("cd_digits0", 64'(digits), 64'(24'h0));
        chk("cd_expired", 64'(expired), 64'(1));
        chk("cd_blink0", 64'(blink), 64'(1));
        bexp = 4'b1001;
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            chk("cd_blink_seq", 64'(blink), 64'(bexp[i]));
        end
        pulse(0, 0, 0, 1, 0, 0);
        chk("ack_flags", 64'({running, expired, blink}), 64'(3'b000));

        // borrow across hours
        set_time(24'h010000);
        pulse(1, 0, 0, 0, 0, 0);
        wait_pulse(k); chk("borrow_period", 64'(k), 64'(4));
        chk("borrow_digits", 64'(digits), 64'(24'h005959));
        @(negedge clk);
        chk("borrow_ascii", ascii_row, 64'h30303A35393A3539);
        pulse(0, 0, 1, 0, 0, 0);

        // count up to maximum, no wrap
        set_time(24'h235958);
        dir = 1'b1;
        pulse(1, 0, 0, 0, 0, 0);
        wait_pulse(k);
        chk("up_digits", 64'(digits), 64'(24'h235959));
        chk("up_expired", 64'(expired), 64'(1));
        quiet(6);
        chk("up_hold", 64'(digits), 64'(24'h235959));
        pulse(0, 0, 1, 0, 0, 0);

        // pause keeps the fractional second
        dir = 1'b0;
        set_time(24'h000005);
        pulse(1, 0, 0, 0, 0, 0);
        wait_pulse(k);
        quiet(1);
        pulse(0, 1, 0, 0, 0, 0);
        chk("pause_run", 64'(running), 64'(0));
        quiet(10);
        pulse(1, 0, 0, 0, 0, 0);
        wait_pulse(k); chk("resume_period", 64'(k), 64'(2));
        chk("resume_digits", 64'(digits), 64'(24'h000003));
        pulse(0, 1, 0, 0, 0, 0);
        pulse(1, 1, 0, 0, 0, 0);
        chk("startstop_pause", 64'(running), 64'(0));
        pulse(0, 0, 1, 0, 0, 0);
        pulse(1, 0, 0, 0, 0, 0);
        chk("zero_start_done", 64'(expired), 64'(1));
        pulse(0, 0, 1, 1, 0, 0);
        chk("clear_ack", 64'({expired, digits}), 64'(25'h0));

        // asynchronous reset while running
        set_time(24'h000009);
        pulse(1, 0, 0, 0, 0, 0);
        quiet(3);
        #2 rst = 1'b1;
        #1;
        chk("arst_digits", 64'(digits), 64'(24'h0));
        chk("arst_flags", 64'({running, expired, blink, sec_pulse}), 64'(4'b0));
        chk("arst_ascii", ascii_row, 64'h30303A30303A3030);
        @(negedge clk);
        rst = 1'b0;

        // random pulses
        for (int c = 0; c < 3000; c++) begin
            sel = 3'($urandom_range(0, 7));
            dir = 1'($urandom_range(0, 1));
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 63) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end
        quiet(2);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
